// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory bus arbiter with fixed priority,
// starvation guard and bus timeout.
module dmem_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_m0_stb,
    input  logic        i_m0_wr_en,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wr_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_rd_data,
    input  logic        i_m1_stb,
    input  logic        i_m1_wr_en,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wr_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_rd_data,
    output logic        o_stb,
    output logic        o_wr_en,
    output logic [31:0] o_addr,
    output logic [31:0] o_wr_data,
    input  logic        i_ack,
    input  logic [31:0] i_read_data,
    output logic        o_busy
);
    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic          req0, req1, grant1, start, sel, done, tmo_hit, we;
    logic [CW-1:0] consec;
    logic [TW-1:0] tmo;

    assign req0    = i_m0_stb | i_m0_wr_en;
    assign req1    = i_m1_stb | i_m1_wr_en;
    // Port 1 only overtakes port 0 once port 0 has used up its consecutive grants
    assign grant1  = req1 & (!req0 | (consec == CW'(MAX_CONSEC)));
    assign start   = (state == IDLE) & (req0 | req1);
    assign done    = (state == WAIT) & i_ack;
    assign tmo_hit = (state == WAIT) & !i_ack & (tmo == TW'(TIMEOUT - 1));
    assign we      = grant1 ? i_m1_wr_en : i_m0_wr_en;
    assign o_busy  = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? ((req0 | req1) ? WAIT : IDLE) :
                     (state == WAIT) ? ((done | tmo_hit) ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sel          <= 1'b0;
            consec       <= '0;
            tmo          <= '0;
            o_stb        <= 1'b0;
            o_wr_en      <= 1'b0;
            o_addr       <= '0;
            o_wr_data    <= '0;
            o_m0_ack     <= 1'b0;
            o_m1_ack     <= 1'b0;
            o_m0_err     <= 1'b0;
            o_m1_err     <= 1'b0;
            o_m0_rd_data <= '0;
            o_m1_rd_data <= '0;
        end else begin
            o_m0_ack <= done & !sel;
            o_m1_ack <= done & sel;
            o_m0_err <= tmo_hit & !sel;
            o_m1_err <= tmo_hit & sel;
            if (start) begin
                sel       <= grant1;
                o_addr    <= grant1 ? i_m1_addr : i_m0_addr;
                o_wr_data <= grant1 ? i_m1_wr_data : i_m0_wr_data;
                o_wr_en   <= we;
                o_stb     <= !we;
                consec    <= (!grant1 & req1) ? consec + CW'(1) : '0;
                tmo       <= '0;
            end
            if ((state == WAIT) && !i_ack) tmo <= tmo + TW'(1);
            if (done | tmo_hit) begin
                o_stb   <= 1'b0;
                o_wr_en <= 1'b0;
            end
            if (done && !sel) o_m0_rd_data <= i_read_data;
            if (done && sel)  o_m1_rd_data <= i_read_data;
        end
    end
endmodule
